trivium_decrypt: RTL

Streaming Trivium decryptor: the receive end of our Trivium keystream encryptor. It loads an 80-bit key and IV, runs the standard 1152-round warm-up, then XORs each incoming ciphertext word with the matching keystream word and emits plaintext under valid/ready flow control. It produces exactly the keystream the encryptor produces for the same key/IV, so a ciphertext stream passed through this block returns the original plaintext.

---
 rtl/trivium_pkg.sv | 30 +++
 rtl/trivium_round.sv | 28 ++
 rtl/trivium_decrypt.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/trivium_pkg.sv
// Shared Trivium definitions for the encryptor/decryptor pair.
// Holds the state width, warm-up length, tap positions and the FSM encoding.
package trivium_pkg;

  localparam int unsigned STATE_W       = 288;
  localparam int unsigned WARMUP_ROUNDS = 1152;

  localparam int unsigned TAP_65  = 65;
  localparam int unsigned TAP_68  = 68;
  localparam int unsigned TAP_90  = 90;
  localparam int unsigned TAP_91  = 91;
  localparam int unsigned TAP_92  = 92;
  localparam int unsigned TAP_161 = 161;
  localparam int unsigned TAP_170 = 170;
  localparam int unsigned TAP_174 = 174;
  localparam int unsigned TAP_175 = 175;
  localparam int unsigned TAP_176 = 176;
  localparam int unsigned TAP_242 = 242;
  localparam int unsigned TAP_263 = 263;
  localparam int unsigned TAP_285 = 285;
  localparam int unsigned TAP_286 = 286;
  localparam int unsigned TAP_287 = 287;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } trivium_state_e;

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round.
// Ports:
//   s_in  : current 288-bit state
//   s_out : state after one round
//   z     : keystream bit produced by this round (taken before the shift)
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] s_in,
  output logic [STATE_W-1:0] s_out,
  output logic               z
);

  logic t_a;
  logic t_b;
  logic t_c;

  always_comb begin
    z   = s_in[TAP_65] ^ s_in[TAP_92] ^ s_in[TAP_161] ^ s_in[TAP_176] ^
          s_in[TAP_242] ^ s_in[TAP_287];
    t_a = s_in[TAP_242] ^ (s_in[TAP_285] & s_in[TAP_286]) ^ s_in[TAP_287] ^ s_in[TAP_68];
    t_b = s_in[TAP_65] ^ (s_in[TAP_90] & s_in[TAP_91]) ^ s_in[TAP_92] ^ s_in[TAP_170];
    t_c = s_in[TAP_161] ^ (s_in[TAP_174] & s_in[TAP_175]) ^ s_in[TAP_176] ^ s_in[TAP_263];
    // Each register shifts toward its MSB; its top bit falls off, the feedback enters at its LSB.
    s_out = {s_in[286:177], t_c, s_in[175:93], t_b, s_in[91:0], t_a};
  end

endmodule

// File: rtl/trivium_decrypt.sv
// Streaming Trivium decryptor: key/IV load, 1152-round warm-up, then
// plaintext = ciphertext ^ keystream, W bits per accepted word.
// Optional macro TRIVIUM_BIT_COUNT_EN adds ks_count (saturating count of
// keystream bits consumed in RUN).
// Ports:
//   clk, reset        : clock, async active-high reset
//   start, key, iv    : load pulse and its key/IV
//   in_valid/in_ready/in_data    : ciphertext input, bit 0 earliest
//   out_valid/out_ready/out_data : plaintext output, bit 0 earliest
//   busy              : high in WARMUP and RUN
//   ks_count          : (TRIVIUM_BIT_COUNT_EN only) keystream bits consumed
module trivium_decrypt
  import trivium_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [79:0]  key,
  input  logic [79:0]  iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
`ifdef TRIVIUM_BIT_COUNT_EN
  ,
  output logic [31:0]  ks_count
`endif
);

  localparam logic [10:0] WARM_LAST = 11'(WARMUP_ROUNDS / W - 1);

  trivium_state_e     fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [10:0]        cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [W-1:0]       out_data_q, out_data_d;
  logic [STATE_W-1:0] state_nxt;
  logic [STATE_W-1:0] state_load;
  logic [W-1:0]       z;
  logic               in_hs;

  // Unrolled W rounds; block gi produces keystream bit gi.
  for (genvar gi = 0; gi < int'(W); gi++) begin : g_round
    logic [STATE_W-1:0] s_prev;
    logic [STATE_W-1:0] s_nxt;
    if (gi == 0) begin : g_first
      assign s_prev = state_q;
    end else begin : g_rest
      assign s_prev = g_round[gi-1].s_nxt;
    end
    trivium_round u_round (
      .s_in  (s_prev),
      .s_out (s_nxt),
      .z     (z[gi])
    );
  end
  assign state_nxt = g_round[W-1].s_nxt;

  assign state_load = {3'b111, 112'b0, iv, 13'b0, key};
  assign in_ready   = (fsm_q == RUN) && !start && (!out_valid_q || out_ready);
  assign in_hs      = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = (fsm_q != IDLE);

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (start) begin
      state_d     = state_load;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      fsm_d       = WARMUP;
    end else begin
      unique case (fsm_q)
        WARMUP: begin
          state_d = state_nxt;
          if (cnt_q == WARM_LAST) begin
            cnt_d = '0;
            fsm_d = RUN;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end
        RUN: begin
          if (in_hs) begin
            out_data_d  = in_data ^ z;
            out_valid_d = 1'b1;
            state_d     = state_nxt;
          end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef TRIVIUM_BIT_COUNT_EN
  logic [31:0] ks_count_q, ks_count_d;
  logic [32:0] ks_sum;

  always_comb begin
    ks_sum     = {1'b0, ks_count_q} + 33'(W);
    ks_count_d = ks_count_q;
    if (start) begin
      ks_count_d = '0;
    end else if (in_hs) begin
      ks_count_d = ks_sum[32] ? '1 : ks_sum[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ks_count_q <= '0;
    end else begin
      ks_count_q <= ks_count_d;
    end
  end

  assign ks_count = ks_count_q;
`endif

endmodule
